// File: rtl/rf215_lvds_tx_if.sv
// I/Q sample handshake into the AT86RF215 LVDS transmitter.
// The master drives a sample pair; the transmitter drives a registered ready.
interface rf215_lvds_tx_if;
    logic [12:0] i_sample;
    logic [12:0] q_sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output i_sample,
        output q_sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  i_sample,
        input  q_sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/rf215_lvds_tx.sv
// AT86RF215 LVDS I/Q serialiser: 32-bit sync-tagged frames, MSB first,
// one bit per txclk edge, with a forwarded half-rate DDR clock.
module rf215_lvds_tx (
    input  logic           txclk,
    input  logic           rst,
    input  logic           enable,
    rf215_lvds_tx_if.slave smp,
    output logic           txd,
    output logic           txclk_out,
    output logic           frame_start,
    output logic           underrun,
    output logic [15:0]    underrun_cnt
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [31:0] FILLER = {2'b10, 14'b0, 2'b01, 14'b0};

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [31:0] sreg;
    logic        buf_full;
    logic [12:0] buf_i;
    logic [12:0] buf_q;

    logic        accept;
    logic        start;
    logic        wrap;
    logic        load_buf;
    logic        buf_full_nxt;
    logic [31:0] buf_frame;
    logic [31:0] next_frame;

    always_comb begin
        accept       = smp.sample_valid && smp.sample_ready;
        // Starting only while txclk_out is low puts bit 31 on its rising edge
        start        = (state == IDLE) && enable && buf_full && !txclk_out;
        wrap         = (state == SHIFT) && (bit_cnt == 5'd31);
        load_buf     = start || (wrap && enable && buf_full);
        buf_full_nxt = buf_full;
        if (accept)
            buf_full_nxt = 1'b1;
        else if (load_buf)
            buf_full_nxt = 1'b0;
        buf_frame    = {2'b10, buf_i, 1'b0, 2'b01, buf_q, 1'b0};
        next_frame   = buf_full ? buf_frame : FILLER;
    end

    // Ready tracks the next buffer state, so it is low on any load edge
    always_ff @(posedge txclk or posedge rst) begin
        if (rst) begin
            buf_full         <= 1'b0;
            smp.sample_ready <= 1'b0;
            buf_i            <= '0;
            buf_q            <= '0;
        end else begin
            buf_full         <= buf_full_nxt;
            smp.sample_ready <= !buf_full_nxt;
            if (accept) begin
                buf_i <= smp.i_sample;
                buf_q <= smp.q_sample;
            end
        end
    end

    always_ff @(posedge txclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            sreg         <= '0;
            txd          <= 1'b0;
            txclk_out    <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            txclk_out   <= !txclk_out;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            unique case (state)
                IDLE: begin
                    txd <= 1'b0;
                    if (start) begin
                        state       <= SHIFT;
                        bit_cnt     <= '0;
                        sreg        <= buf_frame;
                        txd         <= buf_frame[31];
                        frame_start <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!wrap) begin
                        sreg    <= {sreg[30:0], 1'b0};
                        txd     <= sreg[30];
                        bit_cnt <= bit_cnt + 5'd1;
                    end else if (enable) begin
                        sreg        <= next_frame;
                        txd         <= next_frame[31];
                        bit_cnt     <= '0;
                        frame_start <= 1'b1;
                        if (!buf_full) begin
                            underrun <= 1'b1;
                            if (underrun_cnt != 16'hFFFF)
                                underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end else begin
                        state   <= IDLE;
                        txd     <= 1'b0;
                        bit_cnt <= '0;
                        sreg    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf215_lvds_tx.sv
// Directed bench for rf215_lvds_tx: frame table, fillers, enable drop,
// mid-frame reset and counter saturation.
module tb_rf215_lvds_tx;

    logic        txclk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        txd;
    logic        txclk_out;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad = 0;
    int ur_seen = 0;

    rf215_lvds_tx_if bus ();

    rf215_lvds_tx dut (
        .txclk        (txclk),
        .rst          (rst),
        .enable       (enable),
        .smp          (bus),
        .txd          (txd),
        .txclk_out    (txclk_out),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #4 txclk = ~txclk;

    always @(negedge txclk)
        if (underrun === 1'b1) ur_seen++;

    typedef struct {
        logic [12:0] i;
        logic [12:0] q;
        logic [31:0] f;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timeout", nm);
    endtask

    // Called on a negedge; returns on the negedge after the accept edge
    task automatic send(input logic [12:0] i, input logic [12:0] q);
        int n = 0;
        while (bus.sample_ready !== 1'b1 && n < 200) begin
            @(negedge txclk);
            n++;
        end
        if (n >= 200) timeout("send_ready");
        bus.i_sample = i;
        bus.q_sample = q;
        bus.sample_valid = 1'b1;
        @(negedge txclk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_fs(output int lat);
        lat = 0;
        while (frame_start !== 1'b1 && lat < 200) begin
            @(negedge txclk);
            lat++;
        end
        if (lat >= 200) timeout("wait_fs");
    endtask

    // Starts on the frame_start negedge; ends on the bit-0 negedge
    task automatic grab(output logic [31:0] f, input int drop_at);
        for (int p = 0; p < 32; p++) begin
            if (p > 0) @(negedge txclk);
            f[31-p] = txd;
            if (p == drop_at) enable = 1'b0;
        end
    endtask

    logic [31:0] f;
    int          lat;
    logic        prev;

    initial begin
        vec[0] = '{13'h0ABC, 13'h1555, 32'h95786AAA};
        vec[1] = '{13'h0000, 13'h0000, 32'h80004000};
        vec[2] = '{13'h1FFF, 13'h1FFF, 32'hBFFE7FFE};
        vec[3] = '{13'h1000, 13'h0001, 32'hA0004002};
        vec[4] = '{13'h0001, 13'h1000, 32'h80026000};
        vec[5] = '{13'h1234, 13'h0F0F, 32'hA4685E1E};
        vec[6] = '{13'h0555, 13'h0AAA, 32'h8AAA5554};
        vec[7] = '{13'h0FFF, 13'h1001, 32'h9FFE6002};
        vec[8] = '{13'h1800, 13'h07FF, 32'hB0004FFE};
        vec[9] = '{13'h0001, 13'h0001, 32'h80024002};

        bus.i_sample = '0;
        bus.q_sample = '0;
        bus.sample_valid = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rst_txd", {31'b0, txd}, 0);
        check("rst_clk", {31'b0, txclk_out}, 0);
        check("rst_rdy", {31'b0, bus.sample_ready}, 0);
        check("rst_fs", {31'b0, frame_start}, 0);
        check("rst_ur", {31'b0, underrun}, 0);
        check("rst_cnt", {16'b0, underrun_cnt}, 0);
        @(negedge txclk);
        @(negedge txclk);
        rst = 1'b0;
        @(negedge txclk);
        check("rdy_rise", {31'b0, bus.sample_ready}, 1);
        check("clk_tog", {31'b0, txclk_out}, 1);
        check("idle_txd0", {31'b0, txd}, 0);

        // Ten back-to-back frames from the table
        enable = 1'b1;
        fork
            begin
                for (int k = 0; k < 10; k++) send(vec[k].i, vec[k].q);
            end
            begin
                wait_fs(lat);
                for (int k = 0; k < 10; k++) begin
                    if (k > 0) @(negedge txclk);
                    check($sformatf("fs_%0d", k), {31'b0, frame_start}, 1);
                    check($sformatf("ph_%0d", k), {31'b0, txclk_out}, 1);
                    grab(f, -1);
                    check($sformatf("frm_%0d", k), f, vec[k].f);
                end
            end
        join
        check("no_ur", ur_seen, 0);

        // No more samples: fillers; enable dropped at bit 10 of the third
        for (int u = 1; u <= 3; u++) begin
            @(negedge txclk);
            check($sformatf("ffs_%0d", u), {31'b0, frame_start}, 1);
            check($sformatf("fur_%0d", u), {31'b0, underrun}, 1);
            check($sformatf("fcnt_%0d", u), {16'b0, underrun_cnt}, u);
            grab(f, (u == 3) ? 10 : -1);
            check($sformatf("ffrm_%0d", u), f, 32'h80004000);
        end
        @(negedge txclk);
        check("stop_fs", {31'b0, frame_start}, 0);
        check("stop_txd", {31'b0, txd}, 0);
        prev = txclk_out;
        for (int n = 0; n < 6; n++) begin
            @(negedge txclk);
            check("idle_tog", {31'b0, txclk_out}, {31'b0, ~prev});
            check("idle_txd", {31'b0, txd}, 0);
            prev = txclk_out;
        end
        check("ur_total", ur_seen, 3);
        check("cnt_hold", {16'b0, underrun_cnt}, 3);

        // Restart from idle, then reset at bit 20
        enable = 1'b1;
        send(13'h0ABC, 13'h1555);
        wait_fs(lat);
        check("lat_ok", {31'b0, (lat >= 1 && lat <= 2)}, 1);
        f = '0;
        for (int p = 0; p < 20; p++) begin
            if (p > 0) @(negedge txclk);
            f[31-p] = txd;
        end
        @(negedge txclk);
        rst = 1'b1;
        #1;
        check("part_frm", {12'b0, f[31:12]}, 32'h95786);
        check("mrst_txd", {31'b0, txd}, 0);
        check("mrst_clk", {31'b0, txclk_out}, 0);
        check("mrst_rdy", {31'b0, bus.sample_ready}, 0);
        check("mrst_cnt", {16'b0, underrun_cnt}, 0);
        @(negedge txclk);
        rst = 1'b0;
        @(negedge txclk);
        check("rel_rdy", {31'b0, bus.sample_ready}, 1);
        check("rel_txd", {31'b0, txd}, 0);
        check("rel_fs", {31'b0, frame_start}, 0);
        send(13'h0ABC, 13'h1555);
        wait_fs(lat);
        check("re_ph", {31'b0, txclk_out}, 1);
        check("re_cnt", {16'b0, underrun_cnt}, 0);

        // Push the counter near the top, then three more underruns
        force dut.underrun_cnt = 16'hFFFE;
        #1;
        release dut.underrun_cnt;
        check("force_cnt", {16'b0, underrun_cnt}, 32'hFFFE);
        grab(f, -1);
        check("re_frm", f, 32'h95786AAA);
        for (int u = 1; u <= 3; u++) begin
            @(negedge txclk);
            check($sformatf("sur_%0d", u), {31'b0, underrun}, 1);
            check($sformatf("scnt_%0d", u), {16'b0, underrun_cnt}, 32'hFFFF);
            grab(f, (u == 3) ? 0 : -1);
            check($sformatf("sfrm_%0d", u), f, 32'h80004000);
        end
        @(negedge txclk);
        check("end_txd", {31'b0, txd}, 0);
        check("end_cnt", {16'b0, underrun_cnt}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
